instr_fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle processor. Holds the program counter, fetches from instruction memory over a req/ack handshake, and holds the fetched word stable for one execute window. It presents the opcode field to the control unit and decoded fields to the datapath. On retire it selects the next PC from sequential, branch and jump targets using the control/ALU feedback.

---
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, req/ack fetch from instruction memory,
// instruction hold for execute. Optional fetch watchdog enabled by IFU_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic        jump_i,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic        instr_valid,
    output logic        retire,
    output logic        fetch_err
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("instr_fetch_unit: TIMEOUT_CYCLES must be within 2..255");
    end

    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_pc;

`ifdef IFU_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        fetch_err_q, fetch_err_d;
    logic        timeout;

    // cnt_q counts ack-less FETCH cycles already elapsed, so this is the last allowed one
    assign timeout   = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        if (jump_i) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (branch_i && zero_i) begin
            next_pc = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef IFU_TIMEOUT_EN
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = FETCH;
`ifdef IFU_TIMEOUT_EN
                cnt_d = 8'd0;
`endif
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
`ifdef IFU_TIMEOUT_EN
                else if (timeout) begin
                    instr_d     = 32'h0000_0000;
                    fetch_err_d = 1'b1;
                    state_d     = EXEC;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            EXEC: begin
                if (!stall_i) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
`ifdef IFU_TIMEOUT_EN
                    cnt_d = 8'd0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
`ifdef IFU_TIMEOUT_EN
            cnt_q       <= 8'd0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef IFU_TIMEOUT_EN
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign imm         = instr_q[15:0];
    assign instr_valid = (state_q == EXEC);
    assign retire      = (state_q == EXEC) && !stall_i;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, reset/timeout
// sequences and randomized instruction flow checked against a next-PC model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_i, branch_i, zero_i, jump_i;
    logic [31:0] pc, pc_plus4, instr;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        instr_valid, retire, fetch_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_pc;
    logic [31:0] model_instr;
    logic        model_err;

    instr_fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall_i    (stall_i),
        .branch_i   (branch_i),
        .zero_i     (zero_i),
        .jump_i     (jump_i),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr      (instr),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .instr_valid(instr_valid),
        .retire     (retire),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        int          wait_c;
        int          stall_c;
        bit          br;
        bit          z;
        bit          jp;
        logic [31:0] nxt;
    } vec_t;

    vec_t tbl[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
    endfunction

    // Architectural next-PC rule written directly from the ISA description
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                               input bit br, input bit z, input bit jp);
        logic [31:0] p4;
        int          offs;
        p4 = cur + 32'd4;
        if (jp) return (p4 & 32'hF000_0000) | (32'(w[25:0]) * 4);
        offs = int'($signed(w[15:0])) * 4;
        if (br && z) return p4 + 32'(offs);
        return p4;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_pc4"}, pc_plus4, 32'h4);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_opcode"}, 32'(opcode), 32'h0);
        chk({tag, "_req"}, 32'(imem_req), 32'h0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_retire"}, 32'(retire), 32'h0);
        chk({tag, "_err"}, 32'(fetch_err), 32'h0);
    endtask

    // Entered #1 after an edge with the DUT in FETCH at model_pc; leaves it in the next FETCH.
    task automatic run_instr(input int wait_c, input int stall_c, input bit br, input bit z,
                             input bit jp, input logic [31:0] word,
                             input logic [31:0] exp_next, input bit use_exp);
        logic [31:0] nxt;
        chk("fetch_req", 32'(imem_req), 32'h1);
        chk("fetch_addr", imem_addr, model_pc);
        for (int i = 0; i < wait_c; i++) begin
            imem_ack = 1'b0;
            branch_i = 1'($urandom_range(1));
            zero_i   = 1'($urandom_range(1));
            jump_i   = 1'($urandom_range(1));
            stall_i  = 1'($urandom_range(1));
            tick();
            chk("wait_req", 32'(imem_req), 32'h1);
            chk("wait_addr", imem_addr, model_pc);
            chk("wait_instr", instr, model_instr);
            chk("wait_valid", 32'(instr_valid), 32'h0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack    = 1'b0;
        imem_rdata  = $urandom;
        model_instr = word;
        chk("exec_valid", 32'(instr_valid), 32'h1);
        chk("exec_req", 32'(imem_req), 32'h0);
        chk("exec_instr", instr, word);
        chk("exec_opcode", 32'(opcode), 32'(word[31:26]));
        chk("exec_rs", 32'(rs), 32'(word[25:21]));
        chk("exec_rt", 32'(rt), 32'(word[20:16]));
        chk("exec_rd", 32'(rd), 32'(word[15:11]));
        chk("exec_imm", 32'(imm), 32'(word[15:0]));
        chk("exec_pc", pc, model_pc);
        chk("exec_pc4", pc_plus4, model_pc + 32'd4);
        chk("exec_err", 32'(fetch_err), 32'(model_err));
        branch_i = br;
        zero_i   = z;
        jump_i   = jp;
        for (int i = 0; i < stall_c; i++) begin
            stall_i    = 1'b1;
            imem_ack   = 1'($urandom_range(1));
            imem_rdata = $urandom;
            #1;
            chk("stall_retire", 32'(retire), 32'h0);
            tick();
            chk("stall_valid", 32'(instr_valid), 32'h1);
            chk("stall_instr", instr, model_instr);
            chk("stall_pc", pc, model_pc);
        end
        stall_i  = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("retire_pulse", 32'(retire), 32'h1);
        nxt = use_exp ? exp_next : model_next(model_pc, word, br, z, jp);
        tick();
        model_pc = nxt;
        branch_i = 1'b0;
        zero_i   = 1'b0;
        jump_i   = 1'b0;
        chk("next_retire", 32'(retire), 32'h0);
        chk("next_req", 32'(imem_req), 32'h1);
        chk("next_pc", imem_addr, model_pc);
    endtask

    initial begin
        //           pc            word          wait stall br z jp next
        tbl[0]  = '{32'h0000_0000, 32'h2001_0005, 0, 0, 0, 0, 0, 32'h0000_0004};
        tbl[1]  = '{32'h0000_0004, 32'h8C22_0004, 3, 0, 0, 0, 0, 32'h0000_0008};
        tbl[2]  = '{32'h0000_0008, 32'hAC43_0008, 0, 2, 0, 0, 0, 32'h0000_000C};
        tbl[3]  = '{32'h0000_000C, 32'h0800_0004, 0, 0, 0, 0, 1, 32'h0000_0010};
        tbl[4]  = '{32'h0000_0010, 32'h1000_FFFC, 0, 0, 1, 0, 0, 32'h0000_0014};
        tbl[5]  = '{32'h0000_0014, 32'h0800_0004, 1, 0, 0, 0, 1, 32'h0000_0010};
        tbl[6]  = '{32'h0000_0010, 32'h1000_FFFC, 0, 1, 1, 1, 0, 32'h0000_0004};
        tbl[7]  = '{32'h0000_0004, 32'h0800_0100, 0, 0, 1, 1, 1, 32'h0000_0400};
        tbl[8]  = '{32'h0000_0400, 32'h1000_FEFE, 2, 0, 1, 1, 0, 32'hFFFF_FFFC};
        tbl[9]  = '{32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0, 0, 0, 32'h0000_0000};
        tbl[10] = '{32'h0000_0000, 32'h0BFF_FFFF, 0, 0, 0, 0, 1, 32'h0FFF_FFFC};
        tbl[11] = '{32'h0FFF_FFFC, 32'h0800_0100, 0, 0, 0, 0, 1, 32'h1000_0400};
        tbl[12] = '{32'h1000_0400, 32'h1000_7FFF, 0, 0, 1, 1, 0, 32'h1002_0400};

        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        stall_i = 1'b0; branch_i = 1'b0; zero_i = 1'b0; jump_i = 1'b0;
        model_pc = 32'h0; model_instr = 32'h0; model_err = 1'b0;
        #1;
        check_reset("rst");
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_req", 32'(imem_req), 32'h0);
        tick();
        chk("first_fetch_req", 32'(imem_req), 32'h1);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            chk("tbl_pc", imem_addr, tbl[i].pc);
            model_pc = tbl[i].pc;
            run_instr(tbl[i].wait_c, tbl[i].stall_c, tbl[i].br, tbl[i].z, tbl[i].jp,
                      tbl[i].word, tbl[i].nxt, 1'b1);
        end

        // Reset during FETCH with an ack arriving while in reset and across the release edge
        imem_ack = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_reset("rst_fetch");
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        check_reset("rst_fetch_ack");
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("rst_rel_instr", instr, 32'h0);
        chk("rst_rel_valid", 32'(instr_valid), 32'h0);
        chk("rst_rel_req", 32'(imem_req), 32'h1);
        model_pc = 32'h0; model_instr = 32'h0;

        // Reset during EXEC
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        chk("pre_rst_exec_valid", 32'(instr_valid), 32'h1);
        stall_i = 1'b1;
        rst_n   = 1'b0;
        #1;
        check_reset("rst_exec");
        tick();
        rst_n   = 1'b1;
        stall_i = 1'b0;
        tick();
        chk("rst_exec_refetch", 32'(imem_req), 32'h1);
        model_pc = 32'h0; model_instr = 32'h0;

        // Randomized flow against the next-PC model
        for (int n = 0; n < 60; n++) begin
            bit br, z, jp;
            br = 1'($urandom_range(1));
            z  = 1'($urandom_range(1));
            jp = ($urandom_range(3) == 0);
            run_instr(int'($urandom_range(3)), int'($urandom_range(2)), br, z, jp,
                      memword(model_pc), 32'h0, 1'b0);
        end

`ifdef IFU_TIMEOUT_EN
        // Ack on the last allowed cycle wins, then a genuine timeout sets the sticky error
        run_instr(3, 0, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0);
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_wait_req", 32'(imem_req), 32'h1);
            chk("to_wait_err", 32'(fetch_err), 32'h0);
        end
        tick();
        model_instr = 32'h0;
        model_err   = 1'b1;
        chk("to_valid", 32'(instr_valid), 32'h1);
        chk("to_instr", instr, 32'h0);
        chk("to_err", 32'(fetch_err), 32'h1);
        #1;
        chk("to_retire", 32'(retire), 32'h1);
        tick();
        model_pc = model_pc + 32'd4;
        chk("to_next_pc", imem_addr, model_pc);
        run_instr(0, 1, 1'b0, 1'b0, 1'b0, 32'h2001_0001, 32'h0, 1'b0);
`else
        imem_ack = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("nowd_req", 32'(imem_req), 32'h1);
        chk("nowd_addr", imem_addr, model_pc);
        chk("nowd_valid", 32'(instr_valid), 32'h0);
        chk("nowd_err", 32'(fetch_err), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
